if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage for the pipelined LEGv8 core. Holds the program counter and issues one read per cycle to a synchronous-read instruction memory. Captures the returned word with its PC into the IF/ID pipeline register that feeds decode, the control path and register-file read. Supports stalls from the hazard unit, without dropping or duplicating instructions, and PC redirects from branch resolution in EX.

## Interface
- `PC_WIDTH`, 64, PC and address width
- `RESET_PC`, 64'h0, first fetch address after reset; must be 4-byte aligned
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `stall`  in  1  hold PC and IF/ID; from hazard unit
- `br_taken`  in  1  redirect request from EX; overrides `stall`
- `br_target`  in  PC_WIDTH  redirect address; bits [1:0] ignored
- `imem_en`  out  1  read request this cycle
- `imem_addr`  out  PC_WIDTH  read address; equals internal `pc`
- `imem_rdata`  in  32  read data, valid the cycle after `imem_en`
- `if_id_valid`  out  1  IF/ID holds a live instruction
- `if_id_pc`  out  PC_WIDTH  PC of the held instruction
- `if_id_inst`  out  32  held instruction word

## Operation
- State:
  - `pc`: next fetch address
  - `req_v`, `req_pc`: request issued last cycle
  - 1-entry skid buffer: `skid_v`, `skid_pc`, `skid_inst`
  - IF/ID register
- `imem_en = !rst && !stall && !br_taken`. `imem_addr = pc` at all times.
- Issue: when `imem_en` is set, `req_v<=1`, `req_pc<=pc`, and `pc<=pc+4` (modulo 2^PC_WIDTH; wraps to 0). Otherwise `req_v<=0` and `pc` holds, except on redirect.
- Capture with `stall=0` and no redirect:
  - If `skid_v`: IF/ID<={1,skid_pc,skid_inst} and `skid_v<=0`. `req_v` is guaranteed 0 in this case, because no issue occurs during a stall.
  - Else if `req_v`: IF/ID<={1,req_pc,imem_rdata}.
  - Else: `if_id_valid<=0` (bubble).
- Capture with `stall=1` and no redirect:
  - IF/ID holds unchanged.
  - If `req_v`: skid<={1,req_pc,imem_rdata}. The skid is guaranteed empty here, since the previous cycle was unstalled and drained it.
  - Further stall cycles issue nothing, so the skid never overflows.
- Redirect (`br_taken=1`, any `stall`):
  - `pc<={br_target[PC_WIDTH-1:2],2'b00}`.
  - `req_v<=0`; any returning data is discarded.
  - `skid_v<=0`, `if_id_valid<=0`.
  - No fetch is issued in this cycle.
- Reset values:
  - `pc=RESET_PC`
  - `req_v=0`, `skid_v=0`, `if_id_valid=0`
  - `if_id_pc=0`, `if_id_inst=0`, `skid_pc=0`, `skid_inst=0`, `req_pc=0`
  - `imem_en=0` while `rst`=1
- Reset mid-operation: reset overrides everything, including a full skid, pending `req_v`, and `br_taken`. `imem_rdata` in the cycle after reset is ignored because `req_v` is 0.
- Downstream must treat `if_id_inst` as don't-care when `if_id_valid=0`.

## Timing
- Fetch latency: address driven in cycle n, data on `imem_rdata` in cycle n+1, visible on IF/ID in cycle n+2.
- Throughput: 1 instruction per cycle with no stall or redirect.
- First fetch is in the first cycle with `rst=0`, at `RESET_PC`. The first valid IF/ID appears two cycles later.
- Stall of k cycles starting in cycle s (fetch was issued in s-1):
  - IF/ID is frozen for cycles s..s+k-1.
  - The word for `pc` issued in s-1 is captured into the skid at the end of s.
  - At end of s+k (first unstalled cycle), the skid moves to IF/ID while a new fetch issues.
  - No bubble at stall release. Order is preserved with no duplicates.
- Redirect in cycle r:
  - `if_id_valid=0` in cycles r+1 and r+2.
  - Fetch at target in r+1, valid in IF/ID in r+3 (2-cycle branch penalty).
  - A redirect in r+1 restarts the sequence.
- `imem_en` is combinational from `rst`/`stall`/`br_taken`. All outputs except `imem_en` are registered.

## Test plan
- Reset release, `RESET_PC`=0, memory word = address: `if_id_pc` = 0, 4, 8, 0xC… on consecutive cycles, starting 2 cycles after release, `if_id_valid` continuous, `if_id_inst` = `if_id_pc`.
- Stall 3 cycles while IF/ID holds pc 8: IF/ID stays 8 for exactly 3 cycles, then 0xC, 0x10… with no gap, no repeat, and no lost word.
- `br_taken` with `br_target`=0x100 while streaming: 2 cycles `if_id_valid=0`, then 0x100, 0x104. Instructions following the branch never appear.
- `br_taken` and `stall` asserted together, target 0x203: redirect wins. Skid is cleared, next fetch is at 0x200 once `stall` drops, and no stale instruction appears.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC: IF/ID sequence is …FFFC then 0x0, 0x4.
- `rst` asserted mid-stall with the skid full: next cycle has all valids 0 and `pc`=`RESET_PC`. After release, the stream restarts cleanly from `RESET_PC`.

Source files
------------

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC register, synchronous-read imem request,
// one-entry skid buffer and the IF/ID pipeline register.
module if_stage #(
  parameter int unsigned           PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic                imem_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic                if_id_valid,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]         if_id_inst
);

  logic [PC_WIDTH-1:0] pc;
  logic                req_v;
  logic [PC_WIDTH-1:0] req_pc;
  logic                skid_v;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [31:0]         skid_inst;

  assign imem_en   = !rst && !stall && !br_taken;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_v       <= 1'b0;
      req_pc      <= '0;
      skid_v      <= 1'b0;
      skid_pc     <= '0;
      skid_inst   <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_inst  <= '0;
    end else if (br_taken) begin
      // Redirect flushes everything in flight, regardless of stall.
      pc          <= br_target & ~PC_WIDTH'(3);
      req_v       <= 1'b0;
      skid_v      <= 1'b0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc     <= pc + PC_WIDTH'(4);
      req_v  <= 1'b1;
      req_pc <= pc;
      if (skid_v) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= skid_pc;
        if_id_inst  <= skid_inst;
        skid_v      <= 1'b0;
      end else if (req_v) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_inst  <= imem_rdata;
      end else begin
        if_id_valid <= 1'b0;
      end
    end else begin
      // Stalled: IF/ID holds; the word returning this cycle parks in the skid.
      req_v <= 1'b0;
      if (req_v) begin
        skid_v    <= 1'b1;
        skid_pc   <= req_pc;
        skid_inst <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: two instances (RESET_PC 0 and near-wrap)
// compared against an in-order fetch-stream model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_i = 1'b0;
  logic [63:0] tgt_i = '0;

  logic        en0, en1;
  logic [63:0] a0, a1;
  logic [31:0] rd0, rd1;
  logic        v0, v1;
  logic [63:0] p0, p1;
  logic [31:0] i0, i1;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned cycle = 0;
  bit          started = 1'b0;

  // Model: FIFO of issued fetches (pc, issue cycle) awaiting display.
  logic [63:0] m_q   [2][4];
  int unsigned m_cy  [2][4];
  int unsigned m_n   [2];
  logic        m_v   [2];
  logic [63:0] m_pc  [2];
  logic [63:0] m_npc [2];
  bit          m_rz  [2];

  localparam logic [63:0] RPC0 = 64'h0;
  localparam logic [63:0] RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;

  always #5 clk = ~clk;

  if_stage #(.PC_WIDTH(64), .RESET_PC(RPC0)) u_dut0 (
    .clk(clk), .rst(rst_i), .stall(stall_i), .br_taken(br_i), .br_target(tgt_i),
    .imem_en(en0), .imem_addr(a0), .imem_rdata(rd0),
    .if_id_valid(v0), .if_id_pc(p0), .if_id_inst(i0)
  );

  if_stage #(.PC_WIDTH(64), .RESET_PC(RPC1)) u_dut1 (
    .clk(clk), .rst(rst_i), .stall(stall_i), .br_taken(br_i), .br_target(tgt_i),
    .imem_en(en1), .imem_addr(a1), .imem_rdata(rd1),
    .if_id_valid(v1), .if_id_pc(p1), .if_id_inst(i1)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32];
  endfunction

  // Synchronous-read memory; garbage when no request was made.
  always @(posedge clk) begin
    rd0 <= en0 ? mem_word(a0) : $urandom;
    rd1 <= en1 ? mem_word(a1) : $urandom;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_edge(input int unsigned k, input logic [63:0] rpc);
    if (rst_i) begin
      m_n[k] = 0; m_v[k] = 1'b0; m_npc[k] = rpc; m_rz[k] = 1'b1;
    end else begin
      m_rz[k] = 1'b0;
      if (br_i) begin
        m_n[k] = 0; m_v[k] = 1'b0; m_npc[k] = {tgt_i[63:2], 2'b00};
      end else if (!stall_i) begin
        if (m_n[k] > 0 && m_cy[k][0] < cycle) begin
          m_v[k]  = 1'b1;
          m_pc[k] = m_q[k][0];
          for (int unsigned i = 0; i + 1 < m_n[k]; i++) begin
            m_q[k][i]  = m_q[k][i+1];
            m_cy[k][i] = m_cy[k][i+1];
          end
          m_n[k]--;
        end else begin
          m_v[k] = 1'b0;
        end
        m_q[k][m_n[k]]  = m_npc[k];
        m_cy[k][m_n[k]] = cycle;
        m_n[k]++;
        m_npc[k] = m_npc[k] + 64'd4;
      end
    end
  endtask

  task automatic check_outs(input int unsigned k, input logic v, input logic [63:0] p,
                            input logic [31:0] inst);
    check_eq($sformatf("valid%0d", k), {63'd0, v}, {63'd0, m_v[k]});
    if (m_v[k]) begin
      check_eq($sformatf("pc%0d", k), p, m_pc[k]);
      check_eq($sformatf("inst%0d", k), {32'd0, inst}, {32'd0, mem_word(m_pc[k])});
    end
    if (m_rz[k]) begin
      check_eq($sformatf("rst_pc%0d", k), p, 64'd0);
      check_eq($sformatf("rst_inst%0d", k), {32'd0, inst}, 64'd0);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic [63:0] t);
    logic exp_en;
    rst_i = r; stall_i = s; br_i = b; tgt_i = t;
    #1;
    exp_en = !r && !s && !b;
    if (started) begin
      check_eq("en0", {63'd0, en0}, {63'd0, exp_en});
      check_eq("en1", {63'd0, en1}, {63'd0, exp_en});
      check_eq("addr0", a0, m_npc[0]);
      check_eq("addr1", a1, m_npc[1]);
    end
    @(posedge clk);
    cycle++;
    model_edge(0, RPC0);
    model_edge(1, RPC1);
    started = 1'b1;
    #1;
    check_outs(0, v0, p0, i0);
    check_outs(1, v1, p1, i1);
  endtask

  initial begin
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    for (int unsigned i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    // stall of 3 while streaming
    for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    for (int unsigned i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    // redirect while streaming
    cyc(1'b0, 1'b0, 1'b1, 64'h100);
    for (int unsigned i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    // redirect together with stall, skid full beforehand
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 64'h203);
    for (int unsigned i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    for (int unsigned i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    // reset mid-stall with full skid, including a redirect during reset
    for (int unsigned i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 64'h40);
    for (int unsigned i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    // random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, {$urandom, $urandom});
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
